// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory clients, mem_arbiter and the single-ported RAM.
// Handshake: req_ren/req_wen are levels held until req_ready[i] pulses for one cycle;
// a RAM access finishes in the first strobed cycle that samples ram_busy low.
interface mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req_ren;
    logic [NUM_CH-1:0]        req_wen;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        req_ready;
    logic [DATA_W-1:0]        req_rdata;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_store;
    logic                     ram_ren;
    logic                     ram_wen;
    logic [DATA_W-1:0]        ram_load;
    logic                     ram_busy;

    modport slave (
        input  req_ren, req_wen, req_addr, req_wdata, ram_load, ram_busy,
        output req_ready, req_rdata, ram_addr, ram_store, ram_ren, ram_wen
    );

    modport master (
        output req_ren, req_wen, req_addr, req_wdata, ram_load, ram_busy,
        input  req_ready, req_rdata, ram_addr, ram_store, ram_ren, ram_wen
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CH memory clients onto one RAM port: one latched transaction at a time,
// fixed priority or round-robin, one-cycle ready pulse on completion.
module mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 0,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             CLK,
    input  logic             nRST,
    mem_arbiter_if.slave     bus,
    output logic [1:0]       dbg_state,
    output logic [IDX_W-1:0] dbg_ptr
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  grant_q, ptr_q, arb_idx, arb_c_idx;
    logic              arb_found;
    int                arb_c;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [NUM_CH-1:0] req_any;
    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [DATA_W-1:0] ch_wdata [NUM_CH];

    assign req_any = bus.req_ren | bus.req_wen;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
            ch_wdata[i] = bus.req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Search starts at ptr_q in round-robin mode, at 0 otherwise; wraps modulo NUM_CH.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_c     = 0;
        arb_c_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_c = (RR_MODE != 0) ? int'(ptr_q) + k : k;
            if (arb_c >= NUM_CH) arb_c = arb_c - NUM_CH;
            arb_c_idx = IDX_W'(arb_c);
            if (!arb_found && req_any[arb_c_idx]) begin
                arb_found = 1'b1;
                arb_idx   = arb_c_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_found) state_d = ACCESS;
            ACCESS:  if (!bus.ram_busy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.req_ready = '0;
        case (state_q)
            ACCESS: begin
                bus.ram_wen = op_wr_q;
                bus.ram_ren = !op_wr_q;
            end
            DONE:    bus.req_ready = NUM_CH'(1) << grant_q;
            default: ;
        endcase
    end

    // Transaction latch; a request with both strobes set is treated as a write.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            grant_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && arb_found) begin
                grant_q <= arb_idx;
                addr_q  <= ch_addr[arb_idx];
                wdata_q <= ch_wdata[arb_idx];
                op_wr_q <= bus.req_wen[arb_idx];
                ptr_q   <= (int'(arb_idx) == NUM_CH - 1) ? '0 : arb_idx + 1'b1;
            end
            if (state_q == ACCESS && !bus.ram_busy && !op_wr_q)
                rdata_q <= bus.ram_load;
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_store = wdata_q;
    assign bus.req_rdata = rdata_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised RAM arbiter between the CPU memory clients (instruction fetch, data load/store, and later DMA/debug ports) and the single-ported RAM bus. Accepts NUM_CH independent read/write requests and selects one per transaction, using fixed-priority or round-robin arbitration. Address, store data and opcode are registered before issue and held stable until the RAM drops busy. Completion is signalled to the granted requester with a one-cycle ready pulse, and read data is captured into a register.

## Interface
- NUM_CH, 2, number of request channels (≥1); channel 0 = data, 1 = instruction in the CPU build
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- req_ren  in  NUM_CH  per-channel read request, level, held until ready
- req_wen  in  NUM_CH  per-channel write request, level, held until ready
- req_addr  in  NUM_CH*ADDR_W  channel i address at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  channel i store data, same packing
- req_ready  out  NUM_CH  one-hot, one-cycle completion pulse to granted channel
- req_rdata  out  DATA_W  registered read data, shared by all channels, valid while ready pulses and held until next read completes
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_load  in  DATA_W  RAM read data
- ram_busy  in  1  RAM busy; access completes in the first cycle it samples low

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Channel i is requesting when req_ren[i] | req_wen[i].
  - If any channel requests, arbitrate, latch grant index, addr, wdata and op (write if req_wen[i], else read; both set → write), then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - ram_addr and ram_store come from the latches; ram_wen = op write, ram_ren = op read. Exactly one strobe is high.
  - ram_busy = 1: stay in ACCESS.
  - ram_busy = 0: for reads, req_rdata ← ram_load. Go to DONE.
- DONE:
  - req_ready[grant] = 1 and all RAM strobes are 0. Go to IDLE.
  - The requester drops or changes its request in this cycle, so a held request is never re-granted.
- Arbitration:
  - RR_MODE = 0: lowest requesting index wins.
  - RR_MODE = 1: search starts at pointer `ptr`, wraps modulo NUM_CH. On grant, ptr ← (grant + 1) mod NUM_CH, with wrap from NUM_CH−1 to 0.
  - The pointer is only updated on a grant.
- Outside ACCESS: ram_ren = ram_wen = 0; ram_addr and ram_store hold their last latched values.
- A request that deasserts or changes during ACCESS is ignored. The latched transaction completes and ready still pulses.
- Other channels' requests arriving mid-transaction wait; they are not dropped.

## Timing
- Reset (asynchronous, any state including mid-ACCESS):
  - state = IDLE, ptr = 0.
  - req_ready = 0, req_rdata = 0, ram_ren = ram_wen = 0, ram_addr = 0, ram_store = 0.
  - The aborted transaction produces no ready pulse.
- A request seen in IDLE at edge n drives the RAM strobe during cycle n+1.
- If ram_busy is low in cycle n+1, ready is high in cycle n+2. Minimum latency is 2 cycles; occupancy is 3 cycles per transaction.
- Each extra busy cycle adds one cycle of latency. There is no timeout.
- Back-to-back transactions to different channels start every 3 cycles minimum.
- req_ready and req_rdata are registered outputs; there is no combinational path from req_* or ram_* inputs to any output.

## Test plan
- Reset, single read: NUM_CH=2, RR_MODE=0.
  - Stimulus: ch1 ren, addr 0x100; ram_busy=0, ram_load=0xDEADBEEF.
  - Required: ram_ren with ram_addr 0x100 one cycle later; req_ready=2'b10 two cycles after the request; req_rdata=0xDEADBEEF.
- Write with busy stalls:
  - Stimulus: ch0 wen, addr 0x40, wdata 0x12345678; ram_busy high for 3 cycles.
  - Required: ram_wen held with stable addr/data for 4 cycles; req_ready=2'b01 exactly once, one cycle after busy falls; req_rdata unchanged.
- Fixed priority: RR_MODE=0, ch0 and ch1 requesting continuously.
  - Required: ch0 granted first. After ch0 drops its request in the ready cycle, ch1 is granted next with a 3-cycle spacing.
- Round-robin: NUM_CH=4, RR_MODE=1, all channels request continuously, each dropping and re-raising its request after ready.
  - Required: grant order 0,1,2,3,0 (wrap); ptr returns to 1 after the second grant of ch0.
- Ren and wen on the same channel: ch0 ren=wen=1.
  - Required: ram_wen=1 and ram_ren=0.
- Reset mid-ACCESS: assert nRST low while ram_busy=1 during a read.
  - Required: all outputs 0 immediately, no ready pulse. After release, a new request completes normally.
